// File: rtl/kernel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pkg
// Description : Shared types, constants and helpers for the 3x3 convolution
//               kernel loader and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } kernel_loader_state_t;

    localparam int KERNEL_DIM = 3;

    // Pass-through kernel: only the centre tap (element 4) is 1.
    localparam int KERNEL_IDENTITY [KERNEL_DIM*KERNEL_DIM] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

    // Width that holds the exact sum of num_elements signed coefficients.
    function automatic int kernel_sum_width(input int data_width, input int num_elements);
        return data_width + $clog2(num_elements);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_loader.sv
`default_nettype none
// ============================================================================
// Module      : kernel_loader
// Description : Runtime-programmable 3x3 convolution-kernel register file.
//               Coefficients arrive over a valid/ready handshake into a shadow
//               bank; the full set is committed atomically to the active
//               outputs on the next frame-boundary strobe.
// Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//               i_start, i_abort      - begin/restart or discard a load
//               i_coef_valid, i_coef  - coefficient stream (first -> elem N-1)
//               o_coef_ready          - high in LOAD
//               i_frame_start         - frame-boundary commit strobe
//               o_kernel, o_kernel_sum- active kernel and its exact sum
//               o_kernel_update       - one-cycle commit pulse
//               o_pending, o_busy     - status decoded from state
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_loader
    import kernel_pkg::*;
#(
    parameter int KERNEL_NUM_ELEMENTS = 9,
    parameter int DATA_KERNEL_WIDTH   = 8,
    parameter int SUM_WIDTH           = kernel_sum_width(DATA_KERNEL_WIDTH, KERNEL_NUM_ELEMENTS)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic                                i_abort,
    input  logic                                i_coef_valid,
    input  logic signed [DATA_KERNEL_WIDTH-1:0] i_coef,
    output logic                                o_coef_ready,
    input  logic                                i_frame_start,
    output logic signed [DATA_KERNEL_WIDTH-1:0] o_kernel [KERNEL_NUM_ELEMENTS-1:0],
    output logic signed [SUM_WIDTH-1:0]         o_kernel_sum,
    output logic                                o_kernel_update,
    output logic                                o_pending,
    output logic                                o_busy
);

    localparam int IDX_W = $clog2(KERNEL_NUM_ELEMENTS);

    kernel_loader_state_t r_state, w_state_next;

    logic signed [DATA_KERNEL_WIDTH-1:0] r_shadow [KERNEL_NUM_ELEMENTS-1:0];
    logic signed [DATA_KERNEL_WIDTH-1:0] r_kernel [KERNEL_NUM_ELEMENTS-1:0];
    logic signed [SUM_WIDTH-1:0]         r_shadow_sum;
    logic signed [SUM_WIDTH-1:0]         r_sum;
    logic        [IDX_W-1:0]             r_idx;
    logic                                r_update;

    logic                                w_clear;
    logic                                w_accept;
    logic                                w_commit;
    logic                                w_last;
    logic        [IDX_W-1:0]             w_widx;
    logic signed [SUM_WIDTH-1:0]         w_coef_ext;

    assign w_last     = (r_idx == IDX_W'(KERNEL_NUM_ELEMENTS - 1));
    // Stream order is row-major from the top-left, which is the highest index.
    assign w_widx     = IDX_W'(KERNEL_NUM_ELEMENTS - 1) - r_idx;
    assign w_coef_ext = {{(SUM_WIDTH-DATA_KERNEL_WIDTH){i_coef[DATA_KERNEL_WIDTH-1]}}, i_coef};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes. Abort outranks start, which
    // outranks the handshake and the frame strobe. Abort in IDLE is a no-op,
    // so a simultaneous start still launches a load from IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        if (i_abort && (r_state != IDLE)) begin
            w_state_next = IDLE;
        end else if (i_start) begin
            w_state_next = LOAD;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                end
                LOAD: begin
                    if (i_coef_valid) begin
                        w_accept = 1'b1;
                        if (w_last) begin
                            w_state_next = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (i_frame_start) begin
                        w_commit     = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Shadow bank needs no reset: unwritten entries can never be committed.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_shadow[w_widx] <= i_coef;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < KERNEL_NUM_ELEMENTS; i++) begin
                r_kernel[i] <= (KERNEL_IDENTITY[i] != 0) ? DATA_KERNEL_WIDTH'(1) : '0;
            end
            r_sum        <= SUM_WIDTH'(1);
            r_update     <= 1'b0;
            r_idx        <= '0;
            r_shadow_sum <= '0;
        end else begin
            r_update <= w_commit;
            if (w_clear) begin
                r_idx        <= '0;
                r_shadow_sum <= '0;
            end else if (w_accept) begin
                r_idx        <= r_idx + IDX_W'(1);
                r_shadow_sum <= r_shadow_sum + w_coef_ext;
            end
            if (w_commit) begin
                r_kernel <= r_shadow;
                r_sum    <= r_shadow_sum;
            end
        end
    end

    assign o_kernel        = r_kernel;
    assign o_kernel_sum    = r_sum;
    assign o_kernel_update = r_update;
    assign o_coef_ready    = (r_state == LOAD);
    assign o_pending       = (r_state == PENDING);
    assign o_busy          = (r_state != IDLE);

endmodule
`default_nettype wire
